// File: rtl/fifo64_burst_sequencer.sv
// fifo64_burst_sequencer
// Turns single-cycle write/read start triggers into fixed N_WT-cycle wrreq/rdreq
// bursts for the 64-bit turbine-data FIFO.
// Tracks FIFO occupancy and refuses bursts that would overflow or underflow it.
// Also generates the read-data-valid strobe and the sticky output-register enable.

// One burst sequencer (IDLE/BURST with a remaining-cycle down-counter).
// The write and read sides each use one instance.
module fifo64_burst_fsm #(
    parameter int N_WT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic start_i,
    input  logic ok_i,
    output logic en_o,
    output logic done_o,
    output logic reject_o,
    output logic overlap_o
);
    localparam int REM_W = $clog2(N_WT + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               reject_s, overlap_s;

    // State and remaining-cycle register; either reset aborts the burst.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state: accept/reject starts, count the burst down, chain on the last cycle.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        reject_s  = 1'b0;
        overlap_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ok_i) begin
                        state_d = S_BURST;
                        rem_d   = REM_W'(N_WT);
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (rem_q == REM_W'(1)) begin
                    // Last cycle: a start here may begin the next burst with no gap.
                    if (start_i && ok_i) begin
                        state_d = S_BURST;
                        rem_d   = REM_W'(N_WT);
                    end else begin
                        state_d  = S_IDLE;
                        rem_d    = '0;
                        reject_s = start_i;
                    end
                end else begin
                    rem_d     = rem_q - REM_W'(1);
                    overlap_s = start_i;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so that enable and done come straight from flops.
    always_comb begin
        en_d   = (state_d == S_BURST);
        done_d = (state_d == S_BURST) && (rem_d == REM_W'(1));
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    assign en_o      = en_q;
    assign done_o    = done_q;
    assign reject_o  = reject_s;
    assign overlap_o = overlap_s;
endmodule

// Simulation-only occupancy checks: the counter must never leave 0..DEPTH.
module fifo64_burst_sequencer_chk #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input logic             clk,
    input logic             rst,
    input logic             rst_user,
    input logic             wr_en,
    input logic             rd_en,
    input logic [CNT_W-1:0] used_cnt
);
    a_used_in_range: assert property (@(posedge clk) disable iff (rst)
        used_cnt <= CNT_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || rst_user)
        !(wr_en && !rd_en && (used_cnt == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || rst_user)
        !(rd_en && !wr_en && (used_cnt == '0)));
endmodule

module fifo64_burst_sequencer #(
    parameter int N_WT  = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_user,
    input  logic             wr_start,
    input  logic             rd_start,
    output logic             wr_en,
    output logic             rd_en,
    output logic             rd_valid,
    output logic             out_ena,
    output logic             wr_busy,
    output logic             rd_busy,
    output logic             wr_done,
    output logic             rd_done,
    output logic [CNT_W-1:0] used_cnt,
    output logic             ovf_err,
    output logic             udf_err,
    output logic             seq_err
);
    logic             wr_en_s, rd_en_s, wr_done_s, rd_done_s;
    logic             wr_ok_s, rd_ok_s;
    logic             wr_rej_s, rd_rej_s, wr_ovl_s, rd_ovl_s;
    logic [CNT_W-1:0] used_q, used_d;
    logic             rd_valid_q, out_ena_q;
    logic             ovf_q, udf_q, seq_q;

    // Admission checks on the registered count.
    // The word moved by this cycle's own enable is included.
    // This matters only on a burst's last cycle, where a chained start is judged
    // before that final word is counted.
    always_comb begin
        wr_ok_s = (int'(used_q) + int'(wr_en_s)) <= (DEPTH - N_WT);
        rd_ok_s = (int'(used_q) - int'(rd_en_s)) >= N_WT;
    end

    fifo64_burst_fsm #(.N_WT(N_WT)) u_wr_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (rst_user),
        .start_i   (wr_start),
        .ok_i      (wr_ok_s),
        .en_o      (wr_en_s),
        .done_o    (wr_done_s),
        .reject_o  (wr_rej_s),
        .overlap_o (wr_ovl_s)
    );

    fifo64_burst_fsm #(.N_WT(N_WT)) u_rd_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (rst_user),
        .start_i   (rd_start),
        .ok_i      (rd_ok_s),
        .en_o      (rd_en_s),
        .done_o    (rd_done_s),
        .reject_o  (rd_rej_s),
        .overlap_o (rd_ovl_s)
    );

    // Occupancy next value: +1 write only, -1 read only, hold otherwise.
    always_comb begin
        case ({wr_en_s, rd_en_s})
            2'b10:   used_d = used_q + CNT_W'(1);
            2'b01:   used_d = used_q - CNT_W'(1);
            default: used_d = used_q;
        endcase
    end

    // Occupancy counter, read-valid delay and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || rst_user) begin
            used_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            seq_q      <= 1'b0;
        end else begin
            used_q     <= used_d;
            rd_valid_q <= rd_en_s;
            ovf_q      <= ovf_q | wr_rej_s;
            udf_q      <= udf_q | rd_rej_s;
            seq_q      <= seq_q | wr_ovl_s | rd_ovl_s;
        end
    end

    // Output-register enable: set after the first valid read word.
    // Only a full reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ena_q <= 1'b0;
        end else if (rst_user) begin
            out_ena_q <= out_ena_q;
        end else begin
            out_ena_q <= out_ena_q | rd_valid_q;
        end
    end

    fifo64_burst_sequencer_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .rst_user (rst_user),
        .wr_en    (wr_en_s),
        .rd_en    (rd_en_s),
        .used_cnt (used_q)
    );

    assign wr_en    = wr_en_s;
    assign rd_en    = rd_en_s;
    assign wr_busy  = wr_en_s;
    assign rd_busy  = rd_en_s;
    assign wr_done  = wr_done_s;
    assign rd_done  = rd_done_s;
    assign rd_valid = rd_valid_q;
    assign out_ena  = out_ena_q;
    assign used_cnt = used_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;
    assign seq_err  = seq_q;
endmodule
